// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding RV32I load/store unit. It accepts one CPU request,
//   issues one word-aligned memory access, and returns one response pulse.
//   States: IDLE (accept) -> ACCESS (mem_en held until ack/timeout) -> RESP.
//   Requests with an illegal funct3 (and misaligned half/word accesses when
//   trapping is enabled) skip ACCESS and respond with resp_err.
//
// Parameters
//   TIMEOUT : max ACCESS cycles without mem_ack before erroring (1..255)
//
// Build option
//   MISALIGN_TRAP_EN : when defined, misaligned LH/LHU/SH/LW/SW are errors;
//                      otherwise the low address bits are ignored and the
//                      aligned access is performed.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : CPU request (valid/ready, write, funct3, addr, wdata, rd)
//   resp_*            : one-cycle completion (valid, rd, rdata, err)
//   mem_*             : word memory port (en, we, addr, wdata, rdata, ack)
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] rdata_q;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  // Request legality, decided on the incoming request while in IDLE.
  logic req_bad;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    req_bad = 1'b0;
    if (req_write) req_bad = (req_funct3 >= 3'b011);
    else           req_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                             (req_funct3 == 3'b111);
`ifdef MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])            req_bad = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) req_bad = 1'b1;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (req_valid) begin
          err_d   = req_bad;
          state_d = req_bad ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d = ST_RESP;
        end else if (cnt_q == LastCnt) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rd_q     <= 5'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req_valid) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rd_q     <= req_rd;
      end
      if (state_q == ST_ACCESS && mem_ack) rdata_q <= mem_rdata;
    end
  end

  // Store byte enables and lane-replicated data.
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  always_comb begin
    st_we    = 4'b0000;
    st_wdata = wdata_q;
    unique case (funct3_q[1:0])
      2'b00: begin
        st_we    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << {addr_q[1], 1'b0};
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: st_we = 4'b1111;
    endcase
  end

  // Load lane selection and extension from the captured word.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  always_comb begin
    ld_byte = rdata_q[8*addr_q[1:0] +: 8];
    ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    ld_data = 32'd0;
    unique case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = rdata_q;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  // Outputs are forced low combinationally while rst is high, so they read
  // zero even before the first reset edge has been taken.
  logic in_access, in_resp;
  assign in_access = !rst && (state_q == ST_ACCESS);
  assign in_resp   = !rst && (state_q == ST_RESP);

  assign req_ready  = !rst && (state_q == ST_IDLE);
  assign mem_en     = in_access;
  assign mem_addr   = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_we     = (in_access && write_q) ? st_we : 4'b0000;
  assign mem_wdata  = (in_access && write_q) ? st_wdata : 32'd0;
  assign resp_valid = in_resp;
  assign resp_err   = in_resp && err_q;
  assign resp_rd    = (in_resp && !write_q) ? rd_q : 5'd0;
  assign resp_rdata = (in_resp && !write_q && !err_q) ? ld_data : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit (TIMEOUT=16). Inputs change 1 time
// unit after the rising edge; outputs are sampled 1 unit after that.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        req_ready, resp_valid, resp_err, mem_en, mem_ack;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  int n_checks = 0;
  int n_bad    = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE; returns one unit after the accepting edge.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    tick();
    req_valid = 1'b0;
    #1;
  endtask

  // Hold off ack until the ack_cycle-th ACCESS cycle, then ack with word.
  task automatic ack_on(input int ack_cycle, input logic [31:0] word);
    for (int i = 1; i < ack_cycle; i++) begin
      check("mem_en_wait", {31'd0, mem_en}, 32'd1);
      tick();
      #1;
    end
    mem_ack = 1'b1; mem_rdata = word;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    #1;
  endtask

  // Check a RESP cycle, then step back to IDLE.
  task automatic check_resp(input string tag, input logic err, input logic [4:0] rd,
                            input logic [31:0] data);
    check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_err"},   {31'd0, resp_err}, {31'd0, err});
    check({tag, "_rd"},    {27'd0, resp_rd}, {27'd0, rd});
    check({tag, "_rdata"}, resp_rdata, data);
    tick();
    #1;
    check({tag, "_pulse_end"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_we", {28'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // SB 0x103 <- 0xA5
    do_req(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd7);
    check("sb_mem_en", {31'd0, mem_en}, 32'd1);
    check("sb_ready_low", {31'd0, req_ready}, 32'd0);
    check("sb_mem_addr", mem_addr, 32'h0000_0100);
    check("sb_mem_we", {28'd0, mem_we}, 32'h8);
    check("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    ack_on(1, 32'h0);
    check_resp("sb", 1'b0, 5'd0, 32'd0);

    // SH 0x102 <- 0x1234BEEF
    do_req(1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 5'd3);
    check("sh_mem_we", {28'd0, mem_we}, 32'hC);
    check("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    ack_on(2, 32'h0);
    check_resp("sh", 1'b0, 5'd0, 32'd0);

    // SW 0x40 <- 0xCAFEF00D
    do_req(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 5'd0);
    check("sw_mem_we", {28'd0, mem_we}, 32'hF);
    check("sw_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    ack_on(1, 32'h0);
    check_resp("sw", 1'b0, 5'd0, 32'd0);

    // LB rd=5 @0x202, ack on the 3rd ACCESS cycle
    do_req(1'b0, 3'b000, 32'h0000_0202, 32'h0, 5'd5);
    check("lb_mem_addr", mem_addr, 32'h0000_0200);
    check("lb_mem_we", {28'd0, mem_we}, 32'd0);
    ack_on(3, 32'h12F0_4455);
    check_resp("lb", 1'b0, 5'd5, 32'hFFFF_FFF0);

    // LBU, same access
    do_req(1'b0, 3'b100, 32'h0000_0202, 32'h0, 5'd5);
    ack_on(3, 32'h12F0_4455);
    check_resp("lbu", 1'b0, 5'd5, 32'h0000_00F0);

    // LHU @0x102 -> upper half
    do_req(1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd9);
    ack_on(1, 32'h8001_0000);
    check_resp("lhu", 1'b0, 5'd9, 32'h0000_8001);

    // LW @0x48
    do_req(1'b0, 3'b010, 32'h0000_0048, 32'h0, 5'd31);
    ack_on(2, 32'h89AB_CDEF);
    check_resp("lw", 1'b0, 5'd31, 32'h89AB_CDEF);

    // LH @0x301: trapped, or aligned lower-half access
    do_req(1'b0, 3'b001, 32'h0000_0301, 32'h0, 5'd4);
`ifdef MISALIGN_TRAP_EN
    check("lh_mis_no_mem_en", {31'd0, mem_en}, 32'd0);
    check("lh_mis_err", {31'd0, resp_err}, 32'd1);
    tick();
    #1;
`else
    check("lh_mis_mem_addr", mem_addr, 32'h0000_0300);
    ack_on(1, 32'h1234_8001);
    check_resp("lh_mis", 1'b0, 5'd4, 32'hFFFF_8001);
`endif

    // LW timeout: mem_en held for exactly 16 cycles
    do_req(1'b0, 3'b010, 32'h0000_0044, 32'h0, 5'd6);
    n = 0;
    while (mem_en && n < 40) begin
      n++;
      tick();
      #1;
    end
    check("to_cycles", n, 32'd16);
    check_resp("to", 1'b1, 5'd6, 32'd0);

    // Illegal load funct3=011: straight to RESP, no mem_en
    do_req(1'b0, 3'b011, 32'h0000_0010, 32'h0, 5'd2);
    check("ill_ld_no_mem_en", {31'd0, mem_en}, 32'd0);
    check("ill_ld_err", {31'd0, resp_err}, 32'd1);
    check("ill_ld_rdata", resp_rdata, 32'd0);
    tick();
    #1;

    // Illegal store funct3=100
    do_req(1'b1, 3'b100, 32'h0000_0010, 32'h0, 5'd0);
    check("ill_st_no_mem_en", {31'd0, mem_en}, 32'd0);
    check("ill_st_err", {31'd0, resp_err}, 32'd1);
    tick();
    #1;

    // Reset mid-ACCESS abandons the access without a response
    do_req(1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd8);
    tick();
    #1;
    check("rst_mid_mem_en_before", {31'd0, mem_en}, 32'd1);
    rst = 1'b1;
    tick();
    #1;
    check("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    mem_ack = 1'b1;
    tick();
    #1;
    mem_ack = 1'b0;
    check("rst_mid_no_resp", {31'd0, resp_valid}, 32'd0);
    check("rst_mid_idle_no_en", {31'd0, mem_en}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
